// File: rtl/rs_pipe_ctrl_pkg.sv
// Shared types for the relay-station credit controller: drain FSM states,
// relay stage record and credit counter width helper.
package rs_pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } drain_state_e;

  // Relay stage payload width; the top's DATA_WIDTH must match this.
  localparam int STAGE_DATA_W = 32;

  typedef struct packed {
    logic                    valid;
    logic [STAGE_DATA_W-1:0] data;
  } stage_t;

  function automatic int credit_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rs_pipe_credit_ctrl_if.sv
// Producer/consumer handshake bundle for rs_pipe_credit_ctrl; the master issues
// writes, pops and drain requests, the slave is the controller.
interface rs_pipe_credit_ctrl_if
  import rs_pipe_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
) ();

  localparam int CW = credit_w(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] if_din;
  logic                  if_write;
  logic                  if_full_n;
  logic [DATA_WIDTH-1:0] if_dout;
  logic                  if_empty_n;
  logic                  if_read;
  logic                  drain_req;
  logic                  drain_done;
  logic [CW-1:0]         credits;

  modport master (
    output if_din, if_write, if_read, drain_req,
    input  if_full_n, if_dout, if_empty_n, drain_done, credits
  );

  modport slave (
    input  if_din, if_write, if_read, drain_req,
    output if_full_n, if_dout, if_empty_n, drain_done, credits
  );

endinterface

// File: rtl/rs_pipe_ctrl_fifo.sv
// Show-ahead receive FIFO: a write at edge t is readable in the cycle after t.
// No overflow guard here; the caller's credit accounting guarantees a free slot.
module rs_pipe_ctrl_fifo
  import rs_pipe_ctrl_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int FIFO_DEPTH = 16,
  localparam int AW         = $clog2(FIFO_DEPTH),
  localparam int OW         = credit_w(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_vld,
  input  logic [DATA_WIDTH-1:0] wr_dat,
  input  logic                  rd_pop,
  output logic [DATA_WIDTH-1:0] rd_dat,
  output logic                  empty_n,
  output logic [OW-1:0]         occupancy
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;

  always_ff @(posedge clk) begin
    if (wr_vld) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end

  // Pointers carry one wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_vld) wr_ptr <= wr_ptr + 1'b1;
      if (rd_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign rd_dat    = mem[rd_ptr[AW-1:0]];
  assign empty_n   = (wr_ptr != rd_ptr);
  assign occupancy = wr_ptr - rd_ptr;

endmodule

// File: rtl/rs_pipe_credit_ctrl.sv
// Credit-gated relay-station pipe: words ride a PIPE_LEVEL-deep chain into a receive FIFO,
// latency PIPE_LEVEL+1 cycles; if_full_n drops on zero credits or while draining. Stats: RS_PIPE_CREDIT_STATS_EN.
module rs_pipe_credit_ctrl
  import rs_pipe_ctrl_pkg::*;
#(
  parameter  int DATA_WIDTH = STAGE_DATA_W,
  parameter  int PIPE_LEVEL = 10,
  parameter  int FIFO_DEPTH = 16,
  localparam int CW         = credit_w(FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  rs_pipe_credit_ctrl_if.slave bus
`ifdef RS_PIPE_CREDIT_STATS_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [CW-1:0]        max_occ
`endif
);

  localparam logic [CW-1:0] FULL_CREDITS = CW'(FIFO_DEPTH);

  drain_state_e  state_q;
  drain_state_e  state_d;
  logic [CW-1:0] credits_q;
  logic          live_q;
  stage_t        stage_q [PIPE_LEVEL];
  logic          full_n;
  logic          accept;
  logic          pop;
  logic          fifo_empty_n;
  logic          any_valid;
  logic [CW-1:0] occupancy;

  // live_q keeps the write side closed while reset is held.
  assign full_n = live_q && (credits_q != '0) && (state_q == RUN);
  assign accept = bus.if_write && full_n;
  assign pop    = bus.if_read && fifo_empty_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      credits_q <= FULL_CREDITS;
      live_q    <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (accept && !pop)      credits_q <= credits_q - 1'b1;
      else if (pop && !accept) credits_q <= credits_q + 1'b1;
    end
  end

  // Data lanes are not reset; clearing the valids is enough to discard in-flight words.
  always_ff @(posedge clk) begin
    stage_q[0].data <= bus.if_din;
    for (int k = 1; k < PIPE_LEVEL; k++) stage_q[k].data <= stage_q[k-1].data;
    if (reset) begin
      for (int k = 0; k < PIPE_LEVEL; k++) stage_q[k].valid <= 1'b0;
    end else begin
      stage_q[0].valid <= accept;
      for (int k = 1; k < PIPE_LEVEL; k++) stage_q[k].valid <= stage_q[k-1].valid;
    end
  end

  always_comb begin
    any_valid = 1'b0;
    for (int k = 0; k < PIPE_LEVEL; k++) any_valid = any_valid | stage_q[k].valid;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Full credits means the FIFO is empty too; the stage check covers the chain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (bus.drain_req) state_d = DRAIN;
      DRAIN:   if ((credits_q == FULL_CREDITS) && !any_valid) state_d = DONE;
      DONE:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  rs_pipe_ctrl_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_vld    (stage_q[PIPE_LEVEL-1].valid),
    .wr_dat    (stage_q[PIPE_LEVEL-1].data),
    .rd_pop    (pop),
    .rd_dat    (bus.if_dout),
    .empty_n   (fifo_empty_n),
    .occupancy (occupancy)
  );

  assign bus.if_full_n  = full_n;
  assign bus.if_empty_n = fifo_empty_n;
  assign bus.drain_done = (state_q == DONE);
  assign bus.credits    = credits_q;

`ifdef RS_PIPE_CREDIT_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      max_occ   <= '0;
    end else begin
      if (bus.if_write && !full_n && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (occupancy > max_occ) max_occ <= occupancy;
    end
  end
`else
  logic unused_occ;
  assign unused_occ = ^occupancy;
`endif

endmodule
